// File: rtl/exc_pkg.sv
// Shared constants and types for the exception sequencer: ExcCodes, FSM states,
// CP0 select codes and status-mask bit positions.
package exc_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_FLUSH,
    ST_VEC,
    ST_HANDLER,
    ST_RET
  } state_t;

  typedef enum logic [1:0] {
    EPC_EX,
    EPC_ID,
    EPC_ID4
  } epc_sel_t;

  localparam logic [1:0] SEL_STATUS = 2'd0;
  localparam logic [1:0] SEL_CAUSE  = 2'd1;
  localparam logic [1:0] SEL_EPC    = 2'd2;
  localparam logic [1:0] SEL_PERF   = 2'd3;

  localparam int STB_INT = 0;
  localparam int STB_SYS = 1;
  localparam int STB_RI  = 2;
  localparam int STB_OV  = 3;

endpackage

// File: rtl/exc_if.sv
// Pipeline <-> exception sequencer signal bundle; slave = exc_ctrl, master = pipeline.
// exc_count exists only when EXC_PERF_EN is defined.
interface exc_if;
  logic        ex_valid;
  logic        ex_ovf;
  logic        ex_ovf_chk;
  logic [31:0] ex_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_syscall;
  logic        id_unimpl;
  logic        id_eret;
  logic        intr;
  logic        mtc0_we;
  logic [1:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic        ovf_kill;
  logic        flush_id;
  logic        flush_ex;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inta;
  logic [3:0]  status;
  logic [31:0] cause;
  logic [31:0] epc;
`ifdef EXC_PERF_EN
  logic [15:0] exc_count;
`endif

  modport master (
    output ex_valid, ex_ovf, ex_ovf_chk, ex_pc, id_valid, id_pc, id_syscall,
           id_unimpl, id_eret, intr, mtc0_we, mtc0_sel, mtc0_data,
    input  ovf_kill, flush_id, flush_ex, redirect, redirect_pc, inta,
`ifdef EXC_PERF_EN
           exc_count,
`endif
           status, cause, epc
  );

  modport slave (
    input  ex_valid, ex_ovf, ex_ovf_chk, ex_pc, id_valid, id_pc, id_syscall,
           id_unimpl, id_eret, intr, mtc0_we, mtc0_sel, mtc0_data,
    output ovf_kill, flush_id, flush_ex, redirect, redirect_pc, inta,
`ifdef EXC_PERF_EN
           exc_count,
`endif
           status, cause, epc
  );
endinterface

// File: rtl/exc_prio.sv
// Fixed-priority encoder over already-masked requests: OV > RI > SYS > INT.
// Purely combinational, zero latency; no handshake.
module exc_prio
  import exc_pkg::*;
(
  input  logic     ov_req,
  input  logic     ri_req,
  input  logic     sys_req,
  input  logic     int_req,
  output logic     accept,
  output logic [4:0] code,
  output epc_sel_t epc_sel
);

  always_comb begin
    accept  = ov_req | ri_req | sys_req | int_req;
    code    = EXC_INT;
    epc_sel = EPC_ID;
    if (ov_req) begin
      code    = EXC_OV;
      epc_sel = EPC_EX;
    end else if (ri_req) begin
      code    = EXC_RI;
      epc_sel = EPC_ID;
    end else if (sys_req) begin
      code    = EXC_SYS;
      epc_sel = EPC_ID4;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: accept -> FLUSH (FLUSH_CYCLES) -> VEC -> HANDLER -> eret -> RET -> RUN.
// ovf_kill is same-cycle; CP0 state updates one edge after accept; no backpressure, pipeline obeys flush/redirect.
// Optional EXC_PERF_EN adds a saturating accepted-exception counter (exc_count).
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0008,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [3:0]  STATUS_RST   = 4'b0000
) (
  input logic clock,
  input logic resetn,
  exc_if.slave bus
);

  state_t      state, state_nxt;
  logic [3:0]  status_q, status_save;
  logic [4:0]  cause_code;
  logic [31:0] epc_q, epc_nxt;
  logic [1:0]  counter;
  logic        inta_q;
  logic        ov_req, ri_req, sys_req, int_req;
  logic        accept, take, eret_take;
  logic [4:0]  code;
  epc_sel_t    epc_sel;

  assign ov_req  = bus.ex_valid & bus.ex_ovf & bus.ex_ovf_chk & status_q[STB_OV];
  assign ri_req  = bus.id_valid & bus.id_unimpl & status_q[STB_RI];
  assign sys_req = bus.id_valid & bus.id_syscall & status_q[STB_SYS];
  assign int_req = bus.id_valid & bus.intr & status_q[STB_INT];

  exc_prio u_prio (
    .ov_req  (ov_req),
    .ri_req  (ri_req),
    .sys_req (sys_req),
    .int_req (int_req),
    .accept  (accept),
    .code    (code),
    .epc_sel (epc_sel)
  );

  // Requests are only honoured in RUN; the handler runs with everything blocked.
  assign take      = (state == ST_RUN) & accept;
  assign eret_take = (state == ST_HANDLER) & bus.id_valid & bus.id_eret;

  always_comb begin
    state_nxt       = state;
    epc_nxt         = bus.id_pc;
    bus.ovf_kill    = (state == ST_RUN) & ov_req;
    bus.flush_id    = 1'b0;
    bus.flush_ex    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    case (epc_sel)
      EPC_EX:  epc_nxt = bus.ex_pc;
      EPC_ID4: epc_nxt = bus.id_pc + 32'd4;
      default: epc_nxt = bus.id_pc;
    endcase
    case (state)
      ST_RUN: if (take) state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        bus.flush_id = 1'b1;
        bus.flush_ex = 1'b1;
        if (counter == 2'd0) state_nxt = ST_VEC;
      end
      ST_VEC: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = VECTOR_ADDR;
        state_nxt       = ST_HANDLER;
      end
      ST_HANDLER: if (eret_take) state_nxt = ST_RET;
      ST_RET: begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = epc_q;
        bus.flush_id    = 1'b1;
        state_nxt       = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Later assignments deliberately override the mtc0 write on the same edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= ST_RUN;
      status_q    <= STATUS_RST;
      status_save <= 4'h0;
      cause_code  <= 5'd0;
      epc_q       <= 32'h0;
      counter     <= 2'd0;
      inta_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      inta_q <= take & (code == EXC_INT);
      if (bus.mtc0_we) begin
        case (bus.mtc0_sel)
          SEL_STATUS: status_q   <= bus.mtc0_data[3:0];
          SEL_CAUSE:  cause_code <= bus.mtc0_data[6:2];
          SEL_EPC:    epc_q      <= bus.mtc0_data;
          default:    ;
        endcase
      end
      if (state == ST_FLUSH && counter != 2'd0) counter <= counter - 2'd1;
      if (take) begin
        cause_code  <= code;
        epc_q       <= epc_nxt;
        status_save <= status_q;
        status_q    <= 4'h0;
        counter     <= 2'(FLUSH_CYCLES - 1);
      end
      if (eret_take) status_q <= status_save;
    end
  end

  assign bus.inta   = inta_q;
  assign bus.status = status_q;
  assign bus.cause  = {25'd0, cause_code, 2'b00};
  assign bus.epc    = epc_q;

`ifdef EXC_PERF_EN
  logic [15:0] exc_count_q;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      exc_count_q <= 16'h0;
    end else if (take) begin
      if (exc_count_q != 16'hFFFF) exc_count_q <= exc_count_q + 16'd1;
    end else if (bus.mtc0_we && bus.mtc0_sel == SEL_PERF) begin
      exc_count_q <= 16'h0;
    end
  end
  assign bus.exc_count = exc_count_q;
`endif

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer for the pipelined CPU's EX-stage ALU and ID stage.
- Accepts signed-arithmetic overflow from the ALU (0x7fffffff+0x7fffffff), syscall, unimplemented-instruction and external-interrupt requests.
- Prioritises them, kills the offending ALU result and latches cause/EPC.
- Sequences pipeline flush, redirect to the handler vector, and return on eret.

Parameters:
- VECTOR_ADDR, 32'h00000008, handler entry PC.
- FLUSH_CYCLES, 2, cycles flush_id/flush_ex stay asserted (legal 1..4).
- STATUS_RST, 4'b0000, status enable mask after reset.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous active-low reset
- ex_valid  in  1  EX holds a live instruction
- ex_ovf  in  1  ALU IntOverflow
- ex_ovf_chk  in  1  EX op is signed add/sub (ALU uns=0)
- ex_pc  in  32  PC of EX instruction
- id_valid  in  1  ID holds a live instruction
- id_pc  in  32  PC of ID instruction
- id_syscall  in  1  ID decodes syscall
- id_unimpl  in  1  ID decodes unimplemented opcode
- id_eret  in  1  ID decodes eret
- intr  in  1  external interrupt, level
- mtc0_we  in  1  CP0 write strobe
- mtc0_sel  in  2  0=status, 1=cause, 2=epc, 3=ignored
- mtc0_data  in  32  CP0 write data
- ovf_kill  out  1  combinational; suppress EX writeback
- flush_id  out  1  kill ID
- flush_ex  out  1  kill EX
- redirect  out  1  one-cycle PC override
- redirect_pc  out  32  target PC when redirect=1
- inta  out  1  one-cycle interrupt acknowledge
- status  out  4  enable mask {ov,ri,sys,int}
- cause  out  32  ExcCode in [6:2], other bits 0
- epc  out  32  return PC

Behaviour:
- Reset: state RUN, status=STATUS_RST, cause=0, epc=0, status_save=0, counter=0, all control outputs 0.
- States: RUN, FLUSH, VEC, HANDLER, RET.
- RUN, request evaluation in priority order:
  - OV: ex_valid&ex_ovf&ex_ovf_chk&status[3]
  - RI: id_valid&id_unimpl&status[2]
  - SYS: id_valid&id_syscall&status[1]
  - INT: id_valid&intr&status[0]
- ovf_kill is combinational and equals the OV term in RUN. It is 0 in all other states.
- When any request is accepted, on that edge:
  - cause[6:2] = 12 (OV), 10 (RI), 8 (SYS) or 0 (INT)
  - epc = ex_pc (OV), id_pc (RI, INT) or id_pc+4 (SYS), 32-bit wrap
  - status_save = status; status = 0
  - counter = FLUSH_CYCLES-1; go to FLUSH
  - inta = 1 for exactly the next cycle if the cause is INT
- FLUSH: flush_id=flush_ex=1. Decrement counter; when it is 0, go to VEC.
- VEC: redirect=1, redirect_pc=VECTOR_ADDR for one cycle; then go to HANDLER.
- HANDLER: no new request is accepted, regardless of status. An intr that stays high is taken after return.
  - id_valid&id_eret: status=status_save; go to RET.
- RET: redirect=1, redirect_pc=epc for one cycle, flush_id=1; then go to RUN.
- eret in RUN is ignored (no redirect).
- mtc0 write takes effect on the next edge in any state.
  - Same edge as an exception accept: the exception's updates to cause/epc/status win.
  - Same edge as eret restore: the restore wins for status.
- Simultaneous OV and SYS: OV is taken and the syscall is flushed, re-executing after eret.
- resetn low in any state (including mid-FLUSH): state returns to RUN and all registers are cleared on that edge.

Optional Feature:
- Macro EXC_PERF_EN.
- Defined: adds output exc_count [15:0]. It increments on every accepted exception, saturates at 16'hFFFF, resets to 0, and is cleared by mtc0 write with mtc0_sel=3.
- Undefined: no port, no counter, mtc0_sel=3 ignored.

Decomposition:
- Package exc_pkg:
  - ExcCode constants EXC_INT=5'd0, EXC_SYS=5'd8, EXC_RI=5'd10, EXC_OV=5'd12
  - State encoding typedef
  - mtc0_sel codes
  - status bit indices
- Sub-module exc_prio: combinational priority encoder returning accept, code and epc select.

Test Plan:
- OV path: status=4'hF, ex_ovf_chk=1, ALU a=b=0x7fffffff (ex_ovf=1), ex_pc=0x40.
  - Same cycle: ovf_kill=1.
  - Next: cause=0x30, epc=0x40, status=0.
  - flush for 2 cycles, then redirect_pc=0x8.
- Unsigned op gating: ex_ovf=1, ex_ovf_chk=0 → no exception, ovf_kill=0, state stays RUN.
- Simultaneous requests: OV at ex_pc=0x20 plus SYS at id_pc=0x24 → cause=0x30, epc=0x20. After eret, redirect_pc=0x20 and status restored to 4'hF.
- Interrupt masking: intr held with status[0]=0 → ignored. mtc0 status=4'h1 → taken next cycle with inta=1 pulse and epc=id_pc.
- Reset mid-operation: resetn=0 during FLUSH → next cycle state RUN, flush/redirect=0, cause=epc=0.
- Syscall return address: SYS at id_pc=0xFFFFFFFC → epc=0x00000000 (wrap).
